// File: rtl/segrx_pkg.sv
// segrx_pkg: seven-segment pattern constants and receiver FSM states.
package segrx_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
endpackage

// File: rtl/seg_lookup.sv
// seg_lookup: active-low seven-segment pattern to hex code, blank and error flags.
module seg_lookup
    import segrx_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] code,
    output logic       is_blank,
    output logic       is_err
);
    assign is_blank = pat == SEG_BLANK;
    always_comb begin
        code   = 4'h0;
        is_err = 1'b0;
        case (pat)
            SEG_0:     code = 4'h0;
            SEG_1:     code = 4'h1;
            SEG_2:     code = 4'h2;
            SEG_3:     code = 4'h3;
            SEG_4:     code = 4'h4;
            SEG_5:     code = 4'h5;
            SEG_6:     code = 4'h6;
            SEG_7:     code = 4'h7;
            SEG_8:     code = 4'h8;
            SEG_9:     code = 4'h9;
            SEG_A:     code = 4'hA;
            SEG_B:     code = 4'hB;
            SEG_C:     code = 4'hC;
            SEG_D:     code = 4'hD;
            SEG_E:     code = 4'hE;
            SEG_F:     code = 4'hF;
            SEG_BLANK: code = 4'h0;
            default:   is_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg_decode_rx.sv
// seg_decode_rx: debounced seven-segment bus decoder with valid/ready output.
// Define SEGRX_HISTORY_EN to add the 3-deep history port of accepted codes.
module seg_decode_rx
    import segrx_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [6:0] SEG,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_code,
    output logic       out_err,
    output logic       overrun
`ifdef SEGRX_HISTORY_EN
   ,output logic [11:0] history
`endif
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SC = CW'(STABLE_CYCLES);
    logic [6:0] s;
    logic [CW-1:0] cnt, cnt_n;
    state_t st, st_n;
    logic [3:0] code;
    logic blank, err, chg, seg_blank, emit, acc, load;
    seg_lookup u_lookup (.pat(s), .code(code), .is_blank(blank), .is_err(err));
    // SEG is the incoming sample; s is the previous one it is compared against
    assign chg = SEG != s;
    assign seg_blank = SEG == SEG_BLANK;
    assign cnt_n = chg ? CW'(1) : (cnt == SC ? cnt : cnt + 1'b1);
    assign acc = out_valid && out_ready;
    assign load = emit && (!out_valid || acc);
    always_comb begin
        st_n = st;
        emit = 1'b0;
        case (st)
            IDLE:  st_n = seg_blank ? IDLE : TRACK;
            TRACK: begin
                emit = cnt == SC && !blank;
                st_n = seg_blank ? IDLE : (emit && !chg ? HOLD : TRACK);
            end
            HOLD:  st_n = chg ? (seg_blank ? IDLE : TRACK) : HOLD;
            default: st_n = IDLE;
        endcase
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            st        <= IDLE;
            s         <= SEG_BLANK;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_code  <= 4'h0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            st  <= st_n;
            s   <= SEG;
            cnt <= cnt_n;
            if (load) begin
                out_valid <= 1'b1;
                out_code  <= err ? 4'h0 : code;
                out_err   <= err;
            end else if (acc) begin
                out_valid <= 1'b0;
            end
            if (emit && !load) overrun <= 1'b1;
        end
    end
`ifdef SEGRX_HISTORY_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) history <= 12'h000;
        else if (load && !err) history <= {history[7:0], code};
    end
`endif
endmodule
